// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter sharing one single-port register memory between two
// requesters; one access per IDLE -> ACCESS -> DONE pass, all outputs registered.
module mem_rr_arbiter #(
    parameter int DW = 16,
    parameter int AW = 2
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          req_a,
    input  logic          wr_a,
    input  logic [AW-1:0] addr_a,
    input  logic [DW-1:0] wdata_a,
    output logic          gnt_a,
    output logic          rvalid_a,
    output logic [DW-1:0] rdata_a,
    input  logic          req_b,
    input  logic          wr_b,
    input  logic [AW-1:0] addr_b,
    input  logic [DW-1:0] wdata_b,
    output logic          gnt_b,
    output logic          rvalid_b,
    output logic [DW-1:0] rdata_b,
    output logic          mem_sel,
    output logic          mem_wr,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          prio_q, prio_d;
    logic          owner_q, owner_d;
    logic          cmd_wr_q, cmd_wr_d;
    logic [AW-1:0] cmd_addr_q, cmd_addr_d;
    logic [DW-1:0] cmd_wdata_q, cmd_wdata_d;
    logic [DW-1:0] rdata_a_q, rdata_a_d;
    logic [DW-1:0] rdata_b_q, rdata_b_d;
    logic          pick_b;

    // prio and owner use 0 for A and 1 for B.
    always_comb begin
        state_d     = state_q;
        prio_d      = prio_q;
        owner_d     = owner_q;
        cmd_wr_d    = cmd_wr_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_wdata_d = cmd_wdata_q;
        rdata_a_d   = rdata_a_q;
        rdata_b_d   = rdata_b_q;
        pick_b      = req_b && (!req_a || prio_q);

        unique case (state_q)
            IDLE: begin
                if (req_a || req_b) begin
                    owner_d     = pick_b;
                    prio_d      = !pick_b;
                    cmd_wr_d    = pick_b ? wr_b    : wr_a;
                    cmd_addr_d  = pick_b ? addr_b  : addr_a;
                    cmd_wdata_d = pick_b ? wdata_b : wdata_a;
                    state_d     = ACCESS;
                end
            end
            ACCESS: begin
                if (!cmd_wr_q) begin
                    if (owner_q) begin
                        rdata_b_d = mem_rdata;
                    end else begin
                        rdata_a_d = mem_rdata;
                    end
                end
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= IDLE;
            prio_q      <= 1'b0;
            owner_q     <= 1'b0;
            cmd_wr_q    <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
            rdata_a_q   <= '0;
            rdata_b_q   <= '0;
        end else begin
            state_q     <= state_d;
            prio_q      <= prio_d;
            owner_q     <= owner_d;
            cmd_wr_q    <= cmd_wr_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_wdata_q <= cmd_wdata_d;
            rdata_a_q   <= rdata_a_d;
            rdata_b_q   <= rdata_b_d;
        end
    end

    // The cmd registers only change when a winner is picked, so they also
    // provide the hold-last-value behaviour of the memory address/data bus.
    assign mem_sel   = (state_q == ACCESS);
    assign mem_wr    = (state_q == ACCESS) && cmd_wr_q;
    assign mem_addr  = cmd_addr_q;
    assign mem_wdata = cmd_wdata_q;

    assign gnt_a    = (state_q == DONE) && !owner_q;
    assign gnt_b    = (state_q == DONE) && owner_q;
    assign rvalid_a = gnt_a && !cmd_wr_q;
    assign rvalid_b = gnt_b && !cmd_wr_q;
    assign rdata_a  = rdata_a_q;
    assign rdata_b  = rdata_b_q;
    assign busy     = (state_q != IDLE);

endmodule
